// File: rtl/wb_arb2.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb2
// Brief    : Two-master Wishbone arbiter sharing one slave port. Round-robin
//            grant held for the whole cyc, watchdog forces err on stalls.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arb2 #(
    parameter int adr_width = 32,
    parameter int timeout   = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    // master 0
    input  logic [adr_width-1:0] m0_adr_i,
    input  logic [31:0]          m0_dat_i,
    input  logic [3:0]           m0_sel_i,
    input  logic                 m0_we_i,
    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    output logic [31:0]          m0_dat_o,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,
    // master 1
    input  logic [adr_width-1:0] m1_adr_i,
    input  logic [31:0]          m1_dat_i,
    input  logic [3:0]           m1_sel_i,
    input  logic                 m1_we_i,
    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    output logic [31:0]          m1_dat_o,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,
    // slave
    output logic [adr_width-1:0] s_adr_o,
    output logic [31:0]          s_dat_o,
    output logic [3:0]           s_sel_o,
    output logic                 s_we_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    input  logic [31:0]          s_dat_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    // current owner, one-hot
    output logic [1:0]           grant
);

    // State encoding doubles as the one-hot grant vector.
    localparam logic [1:0]  c_IDLE    = 2'b00;
    localparam logic [1:0]  c_OWN0    = 2'b01;
    localparam logic [1:0]  c_OWN1    = 2'b10;
    localparam bit          c_WD_EN   = (timeout != 0);
    localparam logic [15:0] c_WD_LAST = 16'(timeout - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_last;
    logic [15:0] r_cnt;
    logic        w_own0;
    logic        w_own1;
    logic        w_stall;
    logic        w_wd_fire;

    assign w_own0    = (r_state == c_OWN0);
    assign w_own1    = (r_state == c_OWN1);
    assign w_stall   = s_stb_o & ~s_ack_i & ~s_err_i;
    assign w_wd_fire = c_WD_EN && w_stall && (r_cnt == c_WD_LAST);
    assign grant     = r_state;
    assign m0_dat_o  = s_dat_i;
    assign m1_dat_o  = s_dat_i;

    // State register and last-granted flag; reset makes master 0 win first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == c_OWN0) r_last <= 1'b0;
            if (w_state_nxt == c_OWN1) r_last <= 1'b1;
        end
    end

    // Next-state: round-robin from IDLE, hold while owner keeps cyc, direct handover.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) w_state_nxt = r_last ? c_OWN0 : c_OWN1;
                else if (m0_cyc_i)        w_state_nxt = c_OWN0;
                else if (m1_cyc_i)        w_state_nxt = c_OWN1;
            end
            c_OWN0: begin
                if (!m0_cyc_i) w_state_nxt = m1_cyc_i ? c_OWN1 : c_IDLE;
            end
            c_OWN1: begin
                if (!m1_cyc_i) w_state_nxt = m0_cyc_i ? c_OWN0 : c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Outputs: slave request mux and response routing to the owner only.
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        if (w_own0) begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            m0_ack_o = s_ack_i & m0_stb_i;
            m0_err_o = (s_err_i & m0_stb_i) | w_wd_fire;
        end else if (w_own1) begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            m1_ack_o = s_ack_i & m1_stb_i;
            m1_err_o = (s_err_i & m1_stb_i) | w_wd_fire;
        end
    end

    // Watchdog: counts consecutive stalled strobe cycles, restarts on any response,
    // idle strobe, ownership change or its own firing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (!c_WD_EN || (w_state_nxt != r_state) || !w_stall || w_wd_fire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire
